// File: rtl/reg_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// reg_bus_arbiter_pkg
// Shared types and constants for the register-bus arbiter slice.
//   state_t  : arbiter FSM states (IDLE / ACCESS / DONE)
//   owner_t  : which requester currently owns, or last owned, the bus
//   CONT_SAT : saturation value of the contention counter
// No ports (package).
// -----------------------------------------------------------------------------
package reg_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I2C = 1'b0,
    OWN_SPI = 1'b1
  } owner_t;

  localparam logic [7:0] CONT_SAT = 8'hFF;

endpackage

// File: rtl/reg_bus_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin grant generator. Grants are combinational from the
// requests. The last_owner register remembers the most recent winner so that
// a tie goes to the other requester. After reset last_owner is SPI, so I2C
// wins the first tie. The top module leaves this block out when
// REG_ARB_FIXED_PRIO_EN is defined.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_req_i2c     : I2C request
//   i_req_spi     : SPI request
//   i_update      : the grant is being taken this cycle (arbiter in IDLE)
//   o_gnt_i2c     : grant to I2C
//   o_gnt_spi     : grant to SPI
// -----------------------------------------------------------------------------
module rr_arb2
  import reg_bus_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_i2c,
  input  logic i_req_spi,
  input  logic i_update,
  output logic o_gnt_i2c,
  output logic o_gnt_spi
);

  owner_t r_last_owner;
  logic   w_gnt_i2c;
  logic   w_gnt_spi;

  // A lone request always wins. A tie goes to whoever did not win last time.
  assign w_gnt_i2c = i_req_i2c & (~i_req_spi | (r_last_owner == OWN_SPI));
  assign w_gnt_spi = i_req_spi & ~w_gnt_i2c;

  assign o_gnt_i2c = w_gnt_i2c;
  assign o_gnt_spi = w_gnt_spi;

  // Every grant the FSM takes updates the owner history, contended or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= OWN_SPI;
    end else if (i_update && (w_gnt_i2c || w_gnt_spi)) begin
      r_last_owner <= w_gnt_i2c ? OWN_I2C : OWN_SPI;
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bus_arbiter
// Shares the single-ported register-file bus between the I2C control plane
// and the SPI data plane. Each access takes three cycles:
//   IDLE   : the winner is picked and its request is captured
//   ACCESS : a one-cycle registered reg_wr or reg_rd strobe
//   DONE   : a one-cycle ack goes to the owner
// The block also keeps a saturating count of contended arbitrations.
// Configuration macro:
//   REG_ARB_FIXED_PRIO_EN : I2C always wins ties and rr_arb2 is not built.
//                           Without it, ties alternate round-robin.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   i2c_req/we/addr/wdata       : I2C request (held until ack)
//   i2c_ack, i2c_rdata          : I2C completion pulse and read data
//   spi_req/we/addr/wdata       : SPI request (held until ack)
//   spi_ack, spi_rdata          : SPI completion pulse and read data
//   reg_addr, reg_wdata         : register-file address and write data
//   reg_wr, reg_rd              : one-cycle write and read strobes
//   reg_rdata                   : combinational read data from the register file
//   busy                        : FSM is not in IDLE
//   contention_cnt              : saturating count of contended arbitrations
// -----------------------------------------------------------------------------
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2c_req,
  input  logic              i2c_we,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  output logic              i2c_ack,
  output logic [DATA_W-1:0] i2c_rdata,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic              spi_ack,
  output logic [DATA_W-1:0] spi_rdata,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic [7:0]        contention_cnt
);

  state_t            r_state;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_reg_addr;
  logic [DATA_W-1:0] r_reg_wdata;
  logic              r_reg_wr;
  logic              r_reg_rd;
  logic              r_i2c_ack;
  logic              r_spi_ack;
  logic [DATA_W-1:0] r_i2c_rdata;
  logic [DATA_W-1:0] r_spi_rdata;
  logic [7:0]        r_cont_cnt;

  logic              w_gnt_i2c;
  logic              w_gnt_spi;

`ifdef REG_ARB_FIXED_PRIO_EN
  // Fixed priority: I2C wins any tie, so no owner history is needed.
  assign w_gnt_i2c = i2c_req;
  assign w_gnt_spi = spi_req & ~i2c_req;
`else
  logic w_arb_update;

  // The grant is only taken, and the history only updated, in IDLE.
  assign w_arb_update = (r_state == IDLE);

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req_i2c (i2c_req),
    .i_req_spi (spi_req),
    .i_update  (w_arb_update),
    .o_gnt_i2c (w_gnt_i2c),
    .o_gnt_spi (w_gnt_spi)
  );
`endif

  // Main FSM. Every bus, strobe and ack output is registered here, so a req
  // input never reaches an output combinationally. The winner's request is
  // captured in IDLE, so requester inputs that change after the grant are
  // ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= OWN_I2C;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_wr    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_i2c_ack   <= 1'b0;
      r_spi_ack   <= 1'b0;
      r_i2c_rdata <= '0;
      r_spi_rdata <= '0;
      r_cont_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_i2c) begin
            r_owner     <= OWN_I2C;
            r_reg_addr  <= i2c_addr;
            r_reg_wdata <= i2c_wdata;
            r_reg_wr    <= i2c_we;
            r_reg_rd    <= ~i2c_we;
            r_state     <= ACCESS;
          end else if (w_gnt_spi) begin
            r_owner     <= OWN_SPI;
            r_reg_addr  <= spi_addr;
            r_reg_wdata <= spi_wdata;
            r_reg_wr    <= spi_we;
            r_reg_rd    <= ~spi_we;
            r_state     <= ACCESS;
          end
          if (i2c_req && spi_req && (r_cont_cnt != CONT_SAT)) begin
            r_cont_cnt <= r_cont_cnt + 8'd1;
          end
        end

        ACCESS: begin
          // A write leaves the owner's rdata unchanged. Only a read updates it.
          r_reg_wr <= 1'b0;
          r_reg_rd <= 1'b0;
          if (r_reg_rd) begin
            if (r_owner == OWN_I2C) begin
              r_i2c_rdata <= reg_rdata;
            end else begin
              r_spi_rdata <= reg_rdata;
            end
          end
          if (r_owner == OWN_I2C) begin
            r_i2c_ack <= 1'b1;
          end else begin
            r_spi_ack <= 1'b1;
          end
          r_state <= DONE;
        end

        DONE: begin
          r_i2c_ack <= 1'b0;
          r_spi_ack <= 1'b0;
          r_state   <= IDLE;
        end

        default: begin
          r_reg_wr  <= 1'b0;
          r_reg_rd  <= 1'b0;
          r_i2c_ack <= 1'b0;
          r_spi_ack <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign reg_addr       = r_reg_addr;
  assign reg_wdata      = r_reg_wdata;
  assign reg_wr         = r_reg_wr;
  assign reg_rd         = r_reg_rd;
  assign i2c_ack        = r_i2c_ack;
  assign spi_ack        = r_spi_ack;
  assign i2c_rdata      = r_i2c_rdata;
  assign spi_rdata      = r_spi_rdata;
  assign contention_cnt = r_cont_cnt;
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_bus_arbiter
// Self-checking bench for reg_bus_arbiter. The bench keeps a register file
// that the DUT drives. Expected values come from a transaction-level model:
//   - the winner order per round
//   - a shadow copy of the register contents
//   - the expected rdata held by each requester
//   - a saturating contention count
// Defining REG_ARB_FIXED_PRIO_EN switches the model to fixed priority.
// -----------------------------------------------------------------------------
module tb_reg_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i2c_req, i2c_we, spi_req, spi_we;
  logic [7:0] i2c_addr, i2c_wdata, spi_addr, spi_wdata;
  logic       i2c_ack, spi_ack, reg_wr, reg_rd, busy;
  logic [7:0] i2c_rdata, spi_rdata, reg_addr, reg_wdata, reg_rdata, contention_cnt;

  // Register-file environment, with a preload port for directed setup.
  logic [7:0] regFile [256] = '{default: 8'h00};
  logic       preload = 1'b0;
  logic [7:0] preAddr = 8'h00;
  logic [7:0] preData = 8'h00;

  // Reference model state.
  logic [7:0] shadow [256] = '{default: 8'h00};
  logic [7:0] expRdI2c = 8'h00;
  logic [7:0] expRdSpi = 8'h00;
  int         expCnt = 0;
  int         lastWinner = 1;   // 0 = I2C, 1 = SPI

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign reg_rdata = regFile[reg_addr];

  // The register file takes writes only from the DUT's strobe or the preload port.
  always @(posedge clk) begin
    if (preload) regFile[preAddr] <= preData;
    else if (reg_wr) regFile[reg_addr] <= reg_wdata;
  end

  reg_bus_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_ack(i2c_ack), .i2c_rdata(i2c_rdata),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_ack(spi_ack), .spi_rdata(spi_rdata),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .busy(busy), .contention_cnt(contention_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one arbitration round from IDLE. The task is entered at a negedge and
  // drives the chosen requests. Each owner scrambles its own inputs once it
  // has been granted. The round ends at the negedge of the IDLE cycle after
  // the last ack.
  task automatic applyStimulus(input bit doI2c, input bit doSpi,
                               input logic wI, input logic [7:0] aI, input logic [7:0] dI,
                               input logic wS, input logic [7:0] aS, input logic [7:0] dS,
                               input logic [7:0] scrA, input logic [7:0] scrD);
    int         order[$];
    int         who;
    logic       we;
    logic [7:0] addr, data;
    i2c_req = doI2c; i2c_we = wI; i2c_addr = aI; i2c_wdata = dI;
    spi_req = doSpi; spi_we = wS; spi_addr = aS; spi_wdata = dS;
    if (doI2c && doSpi) begin
`ifdef REG_ARB_FIXED_PRIO_EN
      order.push_back(0); order.push_back(1);
`else
      if (lastWinner == 1) begin order.push_back(0); order.push_back(1); end
      else begin order.push_back(1); order.push_back(0); end
`endif
      if (expCnt < 255) expCnt++;
    end else begin
      order.push_back(doI2c ? 0 : 1);
    end
    foreach (order[k]) begin
      who  = order[k];
      we   = (who == 0) ? wI : wS;
      addr = (who == 0) ? aI : aS;
      data = (who == 0) ? dI : dS;
      if (k == 0) @(negedge clk);
      else begin @(negedge clk); @(negedge clk); end
      // ACCESS cycle: the owner changes its inputs, but the bus must keep the captured request.
      if (who == 0) begin i2c_we = ~wI; i2c_addr = scrA; i2c_wdata = scrD; end
      else begin spi_we = ~wS; spi_addr = scrA; spi_wdata = scrD; end
      #1;
      checkOutput($sformatf("reg_wr[%0d]", who), reg_wr, we);
      checkOutput($sformatf("reg_rd[%0d]", who), reg_rd, !we);
      checkOutput($sformatf("reg_addr[%0d]", who), reg_addr, addr);
      if (we) checkOutput($sformatf("reg_wdata[%0d]", who), reg_wdata, data);
      checkOutput("busy_access", busy, 1'b1);
      checkOutput("ack_early", {i2c_ack, spi_ack}, 2'b00);
      lastWinner = who;
      if (we) shadow[addr] = data;
      else if (who == 0) expRdI2c = shadow[addr];
      else expRdSpi = shadow[addr];
      @(negedge clk);
      // DONE cycle
      checkOutput("strobe_done", {reg_wr, reg_rd}, 2'b00);
      checkOutput($sformatf("i2c_ack[%0d]", who), i2c_ack, who == 0);
      checkOutput($sformatf("spi_ack[%0d]", who), spi_ack, who == 1);
      checkOutput("i2c_rdata", i2c_rdata, expRdI2c);
      checkOutput("spi_rdata", spi_rdata, expRdSpi);
      if (who == 0) i2c_req = 1'b0; else spi_req = 1'b0;
    end
    @(negedge clk);
    checkOutput("busy_idle", busy, 1'b0);
    checkOutput("ack_idle", {i2c_ack, spi_ack}, 2'b00);
    checkOutput("contention_cnt", contention_cnt, expCnt[7:0]);
  endtask

  initial begin
    rst_n = 1'b0;
    i2c_req = 0; i2c_we = 0; i2c_addr = 0; i2c_wdata = 0;
    spi_req = 0; spi_we = 0; spi_addr = 0; spi_wdata = 0;
    @(negedge clk); @(negedge clk);
    checkOutput("rst_strobes", {reg_wr, reg_rd, i2c_ack, spi_ack, busy}, 5'b0);
    checkOutput("rst_bus", {reg_addr, reg_wdata}, 16'h0);
    checkOutput("rst_rdata", {i2c_rdata, spi_rdata}, 16'h0);
    checkOutput("rst_cnt", contention_cnt, 8'h00);
    rst_n = 1'b1;

    // Preload address 0x00 with 0xA7 for the SPI read test.
    preload = 1'b1; preAddr = 8'h00; preData = 8'hA7; shadow[0] = 8'hA7;
    @(negedge clk);
    preload = 1'b0;

    $display("[TB] single I2C write");
    applyStimulus(1, 0, 1'b1, 8'h20, 8'h5A, 1'b0, 8'h00, 8'h00, 8'h21, 8'h00);
    checkOutput("regfile_0x20", regFile[8'h20], 8'h5A);

    $display("[TB] single SPI read");
    applyStimulus(0, 1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h01, 8'h00);

    $display("[TB] both requesting for four accesses");
    for (int r = 0; r < 2; r++)
      applyStimulus(1, 1, 1'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    checkOutput("cnt_after_four", contention_cnt, 8'd2);

    $display("[TB] SPI changes inputs after grant");
    applyStimulus(0, 1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h05, 8'h11, 8'h06, 8'h22);
    checkOutput("regfile_0x05", regFile[8'h05], 8'h11);
    checkOutput("regfile_0x06", regFile[8'h06], shadow[8'h06]);

    $display("[TB] reset during write access");
    i2c_req = 1'b1; i2c_we = 1'b1; i2c_addr = 8'h30; i2c_wdata = 8'hC3;
    @(negedge clk);
    #1 checkOutput("pre_rst_wr", reg_wr, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_wr", reg_wr, 1'b0);
    checkOutput("rst_mid_ack", {i2c_ack, spi_ack}, 2'b00);
    checkOutput("rst_mid_busy", busy, 1'b0);
    checkOutput("rst_mid_cnt", contention_cnt, 8'h00);
    i2c_req = 1'b0;
    lastWinner = 1; expCnt = 0; expRdI2c = 8'h00; expRdSpi = 8'h00;
    @(posedge clk); #1;
    checkOutput("rst_no_write", regFile[8'h30], shadow[8'h30]);
    @(negedge clk);
    checkOutput("rst_no_ack", {i2c_ack, spi_ack}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] 300 contended rounds for saturation");
    for (int r = 0; r < 300; r++)
      applyStimulus(1, 1, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                    1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                    8'($urandom), 8'($urandom));
    checkOutput("cnt_saturated", contention_cnt, 8'hFF);

    $display("[TB] random mixed rounds");
    for (int r = 0; r < 40; r++) begin
      bit a, b;
      a = 1'($urandom); b = 1'($urandom);
      if (!a && !b) a = 1'b1;
      applyStimulus(a, b, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                    1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                    8'($urandom), 8'($urandom));
    end
    checkOutput("cnt_final", contention_cnt, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Two-requester arbiter that shares the single-ported register-file access bus between the I2C slave (control plane) and the SPI data plane. It sequences every access as a registered one-cycle read or write strobe, returns captured read data with a one-cycle acknowledge, and counts contention events. It sits between both protocol engines and the register file.

## Interface
Parameters:
- ADDR_W, 8, register address width
- DATA_W, 8, register data width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i2c_req  in  1  I2C requester access request (level; held until ack)
- i2c_we  in  1  1 = write, 0 = read
- i2c_addr  in  ADDR_W  access address
- i2c_wdata  in  DATA_W  write data
- i2c_ack  out  1  one-cycle completion pulse
- i2c_rdata  out  DATA_W  read data, valid while i2c_ack=1
- spi_req, spi_we, spi_addr, spi_wdata, spi_ack, spi_rdata: same as i2c_*, for the SPI requester
- reg_addr  out  ADDR_W  register-file address
- reg_wdata  out  DATA_W  register-file write data
- reg_wr  out  1  write strobe, one cycle
- reg_rd  out  1  read strobe, one cycle
- reg_rdata  in  DATA_W  combinational read data from the register file
- busy  out  1  high in any state other than IDLE
- contention_cnt  out  8  saturating count of cycles where both requests were arbitrated simultaneously

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset → IDLE.
- IDLE: if any req high, pick winner, capture its we/addr/wdata into registers, set owner, go to ACCESS. Otherwise stay.
- Arbitration: round-robin. last_owner register, reset = SPI, so I2C wins the first tie. When both request, grant the one that is not last_owner; if one requests, grant it. last_owner updates on every grant.
- Both requests high in IDLE: contention_cnt += 1, saturating at 8'hFF.
- ACCESS: reg_addr/reg_wdata drive captured values; exactly one of reg_wr (we=1) or reg_rd (we=0) high. For reads, reg_rdata is captured into the owner's rdata register at the end of this cycle. Next state DONE.
- DONE: owner's ack = 1 for one cycle; other ack stays 0. Next state IDLE.
- Non-owner requests are held pending, never dropped; the arbiter re-evaluates them in IDLE.
- Requester inputs changing after grant are ignored.
- Requester must deassert req in the cycle after ack; req still high in IDLE is a new access.
- Write data is not returned: on a write, the rdata of the owner is unchanged.
- Reset values: all outputs 0, reg_addr/reg_wdata 0, i2c_rdata/spi_rdata 0, contention_cnt 0.

## Timing
- Strobes, acks and bus outputs are registered; no combinational path from req to any output.
- req sampled high at edge N → reg_wr/reg_rd high in cycle N+1 → ack high in cycle N+2.
- Back-to-back throughput: one access per 3 cycles; two contending requesters alternate strictly.
- reg_rdata must settle within the ACCESS cycle (register file read is combinational).
- Asynchronous reset mid-access: strobes and acks drop immediately, FSM returns to IDLE, the access is abandoned without ack; a write whose strobe has not yet been registered is not performed.

## Configuration
- REG_ARB_FIXED_PRIO_EN defined: fixed priority, I2C always wins ties; last_owner not used; contention_cnt still counts.
- Undefined (default): round-robin as in Operation.

## Structure
- Shared package: the FSM state enum (IDLE/ACCESS/DONE), the owner enum (OWN_I2C/OWN_SPI), and the contention counter saturation constant.
- Sub-module: rr_arb2, a two-input round-robin grant generator with a last_owner register; it is bypassed under REG_ARB_FIXED_PRIO_EN.
- The FSM and capture registers stay in the top module.

## Test plan
- Single I2C write, addr 0x20, data 0x5A → reg_wr high for exactly 1 cycle with reg_addr 0x20, reg_wdata 0x5A; i2c_ack 2 cycles after req; spi_ack stays 0.
- Single SPI read, addr 0x00, register file returns 0xA7 → reg_rd for 1 cycle; spi_rdata = 0xA7 while spi_ack = 1.
- Both requesters held high for 4 accesses → grant order I2C, SPI, I2C, SPI; contention_cnt = 2. With REG_ARB_FIXED_PRIO_EN defined, I2C is granted whenever both request.
- SPI changes addr/wdata one cycle after grant (0x05/0x11 → 0x06/0x22) → access uses 0x05/0x11.
- rst_n asserted during ACCESS of a write → reg_wr drops asynchronously, no ack, state IDLE, contention_cnt = 0.
- Force 300 contended arbitrations → contention_cnt saturates at 0xFF and does not wrap.
